// File: rtl/aes_sbox_pkg.sv
// Shared definitions for the AES byte-substitution stage.
//   NUM_BYTES / STATE_W : AES state geometry (16 bytes, 128 bits).
//   sb_state_t          : control FSM states of sub_bytes_iter.
//   FIPS_B_IN/FIPS_B_OUT: FIPS-197 Appendix B round-1 SubBytes input/output,
//                         byte i at bits [8i+7:8i].
package aes_sbox_pkg;

  localparam int unsigned NUM_BYTES = 16;
  localparam int unsigned STATE_W   = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sb_state_t;

  localparam logic [STATE_W-1:0] FIPS_B_IN  = 128'h0848f8e9_2a8dc69a_2be2f4a0_bee33d19;
  localparam logic [STATE_W-1:0] FIPS_B_OUT = 128'h3052411e_e55db4b8_f198bfe0_ae1127d4;

endpackage

// File: rtl/sub_bytes_iter_bsbox.sv
// bSbox: combinational merged AES S-box / inverse S-box for one byte.
//   A       : input byte
//   encrypt : 1 = forward S-box, 0 = inverse S-box
//   Q       : substituted byte
// Both directions share one GF(2^8) inverter; the affine map is applied
// after it (forward) or its inverse before it (inverse).
module bSbox (
  input  logic [7:0] A,
  input  logic       encrypt,
  output logic [7:0] Q
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 == a^-1 for a != 0, and maps 0 to 0 as AES requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int unsigned i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int unsigned n);
    return (b << n) | (b >> (8 - n));
  endfunction

  logic [7:0] pre;
  logic [7:0] inv;

  always_comb begin
    pre = encrypt ? A : (rotl(A, 1) ^ rotl(A, 3) ^ rotl(A, 6) ^ 8'h05);
  end

  always_comb begin
    inv = ginv(pre);
  end

  always_comb begin
    Q = encrypt ? (inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63)
                : inv;
  end

endmodule

// File: rtl/sub_bytes_iter.sv
// sub_bytes_iter: iterative SubBytes/InvSubBytes over a 128-bit AES state.
// LANES bSbox copies process LANES bytes per cycle, NSTEP = 16/LANES cycles
// per block, results written back in place into the data register.
//   CLK, RST_N            : clock, asynchronous active-low reset
//   in_valid/in_ready     : input handshake; in_state, in_encrypt sampled on accept
//   out_valid/out_ready   : output handshake; out_state held while stalled
//   busy                  : high while a block is being processed or held
// in_ready depends combinationally on out_ready so a finished block can be
// drained and a new one accepted on the same edge.
module sub_bytes_iter
  import aes_sbox_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  input  logic               in_encrypt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output logic               busy
);

  localparam int unsigned NSTEP = NUM_BYTES / LANES;
  localparam int unsigned SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  sb_state_t          state_q;
  sb_state_t          state_d;
  logic [STATE_W-1:0] data_q;
  logic [STATE_W-1:0] data_d;
  logic [SW-1:0]      step_q;
  logic               enc_q;
  logic               accept;
  logic               last_step;

  logic [7:0] lane_in  [LANES];
  logic [7:0] lane_out [LANES];

  assign accept    = in_valid && in_ready;
  assign last_step = (step_q == SW'(NSTEP - 1));
  assign out_state = data_q;

  // Lane l of step s handles byte s*LANES + l.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_in[l] = data_q[(32'(step_q) * LANES + l) * 8 +: 8];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    bSbox u_sbox (
      .A       (lane_in[l]),
      .encrypt (enc_q),
      .Q       (lane_out[l])
    );
  end

  always_comb begin
    data_d = data_q;
    for (int unsigned l = 0; l < LANES; l++) begin
      data_d[(32'(step_q) * LANES + l) * 8 +: 8] = lane_out[l];
    end
  end

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = RUN;
      RUN:  if (last_step) state_d = DONE;
      DONE: if (out_ready) state_d = in_valid ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: in_ready = 1'b1;
      RUN:  busy = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  // Datapath: load on accept, substitute in place while running.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      data_q <= '0;
      step_q <= '0;
      enc_q  <= 1'b0;
    end else if (accept) begin
      data_q <= in_state;
      enc_q  <= in_encrypt;
      step_q <= '0;
    end else if (state_q == RUN) begin
      data_q <= data_d;
      step_q <= last_step ? '0 : step_q + 1'b1;
    end
  end

endmodule

// File: doc/sub_bytes_iter.md
Name: sub_bytes_iter

Overview:
- Iterative AES SubBytes/InvSubBytes stage that consumes a 128-bit AES state and returns the byte-substituted state.
- Sits directly upstream of ShiftRows in the round datapath and is the consumer-side wrapper around the combinational merged S-box (bSbox).
- Time-multiplexes LANES bSbox instances over 16 bytes, trading latency for area, with valid/ready handshakes on both sides.

Parameters:
- LANES, 4, number of bSbox instances used in parallel; legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
- NSTEP, 16/LANES (derived, not overridable), number of substitution cycles per block.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream offers a block.
- in_ready  output  1  block accepted when in_valid && in_ready at a CLK edge.
- in_state  input  128  byte i = in_state[8i+7:8i].
- in_encrypt  input  1  1 = S-box, 0 = inverse S-box; sampled with the block.
- out_valid  output  1  result available.
- out_ready  input  1  downstream consumes when out_valid && out_ready.
- out_state  output  128  substituted state, same byte ordering as in_state.
- busy  output  1  high in RUN or DONE.

Behaviour:
- One clock (CLK); reset RST_N is asynchronous, active-low.
- Reset values: FSM in IDLE; out_valid=0, busy=0, in_ready=1; data register, step counter and encrypt flag are all 0, so out_state=0.
- FSM states:
  - IDLE: in_ready=1. On accept, load the data register with in_state, latch in_encrypt, set step=0, go to RUN.
  - RUN: each cycle, bytes step*LANES .. step*LANES+LANES-1 pass through the LANES bSbox instances with the latched encrypt flag. The results are written back in place at the edge, and step increments. After step NSTEP-1 is written, go to DONE.
  - DONE: out_valid=1, out_state = data register, held stable until out_ready.
- Input ready rule: in_ready = (IDLE) || (DONE && out_ready). This is a combinational path from out_ready to in_ready.
- Exits from DONE on the handshake edge:
  - Output handshake and a new input accept in the same edge: load the new block and go straight to RUN (back-to-back).
  - Output handshake only: go to IDLE.
- Latency: block accepted at edge k; out_valid is high after edge k+NSTEP. With LANES=4, out_valid rises 4 cycles after accept.
- Throughput: one block per NSTEP+1 cycles with out_ready held high.
- Byte order: byte 0 is processed in step 0. Bytes not yet processed hold their input values; processed bytes hold substituted values.
- in_valid and in_encrypt are ignored outside the accept condition. in_state/in_encrypt changes during RUN have no effect.
- Stall: out_ready low in DONE holds out_valid=1 and out_state constant indefinitely.
- Reset mid-operation: an asserted RST_N low in any state immediately returns to reset values. The in-flight block is dropped; no partial result is emitted.
- Step counter width is max(1, clog2(NSTEP)). Step is a don't-care outside RUN but is held at 0.
- No X propagation: out_state is always a registered value.

Decomposition:
- Shared package aes_sbox_pkg holds:
  - NUM_BYTES=16 and the state width of 128;
  - the FSM state typedef (IDLE, RUN, DONE);
  - the FIPS-197 test constants used by the bench.
- Lanes reuse the existing bSbox module unchanged; LANES copies are generated with a lane-select mux on the data register.
- No further sub-module.

Test Plan:
- Single byte check, LANES=4: encrypt=1, state with byte0=0x00, byte1=0x53, byte2=0x01, rest 0x00 -> out bytes 0x63, 0xED, 0x7C, rest 0x63; out_valid rises 4 cycles after accept.
- Inverse path: encrypt=0, byte0=0x63, byte1=0xED, rest 0x63 -> out byte0=0x00, byte1=0x53, rest 0x00.
- FIPS-197 App. B round-1 vector: in bytes 0..15 = 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08 -> out d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30. Repeat with LANES=1, 2, 8, 16; latency must equal NSTEP.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 10 cycles in DONE -> out_state stable, in_ready=0.
  - Then assert out_ready with in_valid=1 -> same-edge handshake on both sides; the next result arrives NSTEP+1 cycles after the previous one.
- Reset mid-RUN: assert RST_N=0 at step 2 -> out_valid=0, out_state=0, in_ready=1 asynchronously. After release, a fresh block completes correctly with no stale bytes.
- Encrypt latch: toggle in_encrypt during RUN -> result matches the mode sampled at accept.
